gpio_arbiter: RTL and testbench
===============================

Name: gpio_arbiter

Overview:
Shares the single gpio register block among NUM_REQ requesters (CPU bus bridge, PWM engine, debug UART, and others).
- Arbitrates requests round-robin and executes one masked read-modify-write per grant.
- Drives the gpio block's we/wdata and samples its rdata.
- Returns a one-cycle ack plus the post-write register value to the winning requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, gpio register width; must match the gpio block

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request level; hold until ack
op  in  2*NUM_REQ  per-requester op, slice i = op[2i+1:2i]: 00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE
mask  in  NUM_REQ*DATA_W  per-requester bit mask, slice i = [DATA_W*i +: DATA_W]
data  in  NUM_REQ*DATA_W  per-requester write data (WRITE only)
ack  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_data  out  DATA_W  gpio value after the op; valid while ack != 0
busy  out  1  high in any state other than IDLE
gpio_we  out  1  to gpio block we
gpio_wdata  out  DATA_W  to gpio block wdata
gpio_rdata  in  DATA_W  from gpio block rdata (current register value)

Behaviour:
- Reset (clk, reset: synchronous, active-high): state=IDLE, rr_ptr=0, all outputs 0 (ack, rsp_data, busy, gpio_we, gpio_wdata).
- FSM states:
  - IDLE: if req != 0, pick the first set req bit scanning rr_ptr, rr_ptr+1, … mod NUM_REQ. Latch grant index, op, mask and data into registers; go to EXEC. Otherwise stay in IDLE.
  - EXEC: gpio_we=1 for exactly this cycle. gpio_wdata = f(gpio_rdata, latched op/mask/data); go to ACK.
  - ACK: ack[grant]=1, rsp_data=gpio_rdata (already updated), rr_ptr=(grant+1) mod NUM_REQ; go to IDLE.
- Write function f:
  - WRITE: (old & ~mask) | (data & mask)
  - SET: old | mask
  - CLEAR: old & ~mask
  - TOGGLE: old ^ mask
  - data is ignored for SET, CLEAR and TOGGLE.
- Latency and throughput: req sampled in IDLE at cycle N; gpio_we asserted at N+1; ack at N+2. Maximum throughput is one op per 3 cycles.
- gpio_we is never asserted outside EXEC. gpio_wdata is 0 outside EXEC.
- Requester dropping req after being granted: the op still completes and the ack is still issued (command was latched).
- Requester holding req through its ack cycle: it is re-arbitrated in the next IDLE as a new op, at lowest priority because rr_ptr has advanced past it.
- Inputs changing after IDLE sampling have no effect on the current op.
- mask=0: the write still occurs (value unchanged) and the ack is still issued.
- Reset mid-operation: return to IDLE immediately. No further gpio_we. The pending ack is dropped. Register contents are already as the gpio block left them.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
GPIO_ARB_LOCK_EN
- Enabled:
  - Adds input lock [NUM_REQ].
  - If lock[grant]=1 in the ACK cycle, the arbiter records lock_owner=grant.
  - In the following IDLE cycles, only req[lock_owner] is eligible; others wait.
  - The lock is released when the owner completes an op with lock=0, or when req[lock_owner]=0 in IDLE (normal round-robin then resumes that same cycle).
  - lock_owner is cleared on reset.
- Disabled: the port is absent and arbitration is pure round-robin.

Decomposition:
- Package gpio_arb_pkg:
  - op encodings OP_WRITE/OP_SET/OP_CLEAR/OP_TOGGLE
  - FSM state encodings ST_IDLE/ST_EXEC/ST_ACK
  - function gpio_rmw(old, op, mask, data)
- Sub-module gpio_rr_pick: combinational round-robin picker. Inputs req and rr_ptr; outputs one-hot grant, grant index, and valid.

Test Plan:
1. Single requester: gpio=0x0000_0000; req[1] WRITE mask=0x0000_00FF data=0x1234_5678 → gpio_we at N+1, ack[1] at N+2, rsp_data=0x0000_0078.
2. SET/CLEAR/TOGGLE sequence from 0x0000_00F0: SET 0x0F → 0x0000_00FF; CLEAR 0x3C → 0x0000_00C3; TOGGLE 0xFFFF_0000 → 0xFFFF_00C3.
3. Fairness: all 4 req held, rr_ptr=0 → ack order 0,1,2,3,0 with acks spaced exactly 3 cycles apart; gpio_we never asserted two cycles in a row.
4. Req withdrawal: req[2] dropped in the EXEC cycle → ack[2] still pulses and the write is applied.
5. Reset asserted in the EXEC cycle → next cycle state IDLE, gpio_we=0, no ack issued, rr_ptr=0.
6. GPIO_ARB_LOCK_EN: req[0] with lock=1 plus req[3] pending → requester 0 wins 3 consecutive ops; lock=0 on the 3rd op → requester 3 is served next.

Source files
------------

// File: rtl/gpio_arb_pkg.sv
// Shared types and the read-modify-write helper for the gpio register arbiter.
// The helper is bitwise so it serves any register width.
package gpio_arb_pkg;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'b00,
      OP_SET    = 2'b01,
      OP_CLEAR  = 2'b10,
      OP_TOGGLE = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_ACK  = 2'b10
   } state_e;

   function automatic logic gpio_rmw(input logic old, input op_e op,
                                     input logic mask, input logic data);
      logic res;
      unique case (op)
         OP_WRITE:  res = (old & ~mask) | (data & mask);
         OP_SET:    res = old | mask;
         OP_CLEAR:  res = old & ~mask;
         OP_TOGGLE: res = old ^ mask;
         default:   res = old;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/gpio_rr_pick.sv
// Combinational round-robin picker: first set request scanning from rr_ptr upward.
module gpio_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               valid
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!valid && req[idx]) begin
            valid      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/gpio_arbiter.sv
// Round-robin arbiter running one masked read-modify-write on the gpio block per grant.
// Define GPIO_ARB_LOCK_EN to add the per-requester lock input (sticky ownership).
module gpio_arbiter
   import gpio_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [2*NUM_REQ-1:0]      op,
   input  logic [NUM_REQ*DATA_W-1:0] mask,
   input  logic [NUM_REQ*DATA_W-1:0] data,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      busy,
   output logic                      gpio_we,
   output logic [DATA_W-1:0]         gpio_wdata,
   input  logic [DATA_W-1:0]         gpio_rdata
`ifdef GPIO_ARB_LOCK_EN
   ,
   input  logic [NUM_REQ-1:0]        lock
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_e             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant_idx_q;
   logic [NUM_REQ-1:0] grant_oh_q;
   logic [NUM_REQ-1:0] ack_q;

   op_e                op_q;
   logic [DATA_W-1:0]  mask_q;
   logic [DATA_W-1:0]  data_q;

   op_e                op_arr   [NUM_REQ];
   logic [DATA_W-1:0]  mask_arr [NUM_REQ];
   logic [DATA_W-1:0]  data_arr [NUM_REQ];

   logic [NUM_REQ-1:0] pick_req;
   logic [NUM_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_vld;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
      assign op_arr[i]   = op_e'(op[2*i +: 2]);
      assign mask_arr[i] = mask[DATA_W*i +: DATA_W];
      assign data_arr[i] = data[DATA_W*i +: DATA_W];
   end

`ifdef GPIO_ARB_LOCK_EN
   logic             lock_vld;
   logic [IDX_W-1:0] lock_owner;

   // A live lock narrows eligibility to the owner; an idle owner lets round-robin resume now.
   always_comb begin
      pick_req = req;
      if (lock_vld && req[lock_owner]) begin
         pick_req             = '0;
         pick_req[lock_owner] = 1'b1;
      end
   end
`else
   assign pick_req = req;
`endif

   gpio_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req       (pick_req),
      .rr_ptr    (rr_ptr),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .valid     (pick_vld)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         grant_idx_q <= '0;
         grant_oh_q  <= '0;
         ack_q       <= '0;
`ifdef GPIO_ARB_LOCK_EN
         lock_vld    <= 1'b0;
         lock_owner  <= '0;
`endif
      end else begin
         ack_q <= '0;
         unique case (state)
            ST_IDLE: begin
`ifdef GPIO_ARB_LOCK_EN
               if (lock_vld && !req[lock_owner])
                  lock_vld <= 1'b0;
`endif
               if (pick_vld) begin
                  state       <= ST_EXEC;
                  grant_idx_q <= pick_idx;
                  grant_oh_q  <= pick_grant;
               end
            end
            ST_EXEC: begin
               state <= ST_ACK;
               ack_q <= grant_oh_q;
            end
            ST_ACK: begin
               state  <= ST_IDLE;
               rr_ptr <= (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
`ifdef GPIO_ARB_LOCK_EN
               lock_vld   <= lock[grant_idx_q];
               lock_owner <= grant_idx_q;
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Command capture: inputs are frozen at grant time, so later changes cannot disturb the op.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && pick_vld) begin
         op_q   <= op_arr[pick_idx];
         mask_q <= mask_arr[pick_idx];
         data_q <= data_arr[pick_idx];
      end
   end

   assign gpio_we = (state == ST_EXEC);
   assign busy    = (state != ST_IDLE);
   assign ack     = ack_q;

   always_comb begin
      gpio_wdata = '0;
      if (gpio_we) begin
         for (int b = 0; b < DATA_W; b++)
            gpio_wdata[b] = gpio_rmw(gpio_rdata[b], op_q, mask_q[b], data_q[b]);
      end
   end

   // The gpio block has already absorbed the write, so its readback is the post-op value.
   assign rsp_data = (ack_q != '0) ? gpio_rdata : '0;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Scoreboard bench for gpio_arbiter with a behavioural gpio register block.
// Lock scenario is exercised only when GPIO_ARB_LOCK_EN is defined.
module tb_gpio_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req;
   logic [2*NUM_REQ-1:0]      op;
   logic [NUM_REQ*DATA_W-1:0] mask;
   logic [NUM_REQ*DATA_W-1:0] data;
   logic [NUM_REQ-1:0]        ack;
   logic [DATA_W-1:0]         rsp_data;
   logic                      busy;
   logic                      gpio_we;
   logic [DATA_W-1:0]         gpio_wdata;
   logic [DATA_W-1:0]         gpio_rdata;
`ifdef GPIO_ARB_LOCK_EN
   logic [NUM_REQ-1:0]        lock;
`endif

   logic [DATA_W-1:0] gpio_reg;
   logic              load_en;
   logic [DATA_W-1:0] load_val;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   typedef struct {
      int                idx;
      logic [DATA_W-1:0] val;
   } exp_t;
   exp_t sb_q[$];

   logic [DATA_W-1:0] model_gpio;
   logic              we_prev = 1'b0;

   gpio_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .op         (op),
      .mask       (mask),
      .data       (data),
      .ack        (ack),
      .rsp_data   (rsp_data),
      .busy       (busy),
      .gpio_we    (gpio_we),
      .gpio_wdata (gpio_wdata),
      .gpio_rdata (gpio_rdata)
`ifdef GPIO_ARB_LOCK_EN
      ,
      .lock       (lock)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (gpio_we)      gpio_reg <= gpio_wdata;
      else if (load_en) gpio_reg <= load_val;
   end
   assign gpio_rdata = gpio_reg;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] model_rmw(input logic [DATA_W-1:0] old, input logic [1:0] o,
                                                   input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] d);
      case (o)
         2'b00:   return (old & ~m) | (d & m);
         2'b01:   return old | m;
         2'b10:   return old & ~m;
         default: return old ^ m;
      endcase
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (reset === 1'b0) begin
         if (gpio_we) check_val("we_b2b", {63'd0, we_prev}, 64'd0);
         else         check_val("wdata_idle", {32'd0, gpio_wdata}, 64'd0);
         if (ack != '0) begin
            if (sb_q.size() == 0) check_val("ack_unexp", {60'd0, ack}, 64'd0);
            else begin
               e = sb_q.pop_front();
               check_val("ack_idx", {60'd0, ack}, 64'(1) << e.idx);
               check_val("rsp_data", {32'd0, rsp_data}, {32'd0, e.val});
            end
         end else begin
            check_val("rsp_idle", {32'd0, rsp_data}, 64'd0);
         end
      end
      we_prev <= gpio_we;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [DATA_W-1:0] v);
      load_en = 1'b1;
      load_val = v;
      tick();
      load_en = 1'b0;
      model_gpio = v;
   endtask

   task automatic set_req(input int i, input logic [1:0] o, input logic [DATA_W-1:0] m,
                          input logic [DATA_W-1:0] d);
      op[2*i +: 2]           = o;
      mask[DATA_W*i +: DATA_W] = m;
      data[DATA_W*i +: DATA_W] = d;
      req[i]                 = 1'b1;
   endtask

   task automatic expect_op(input int i, input logic [1:0] o, input logic [DATA_W-1:0] m,
                            input logic [DATA_W-1:0] d);
      exp_t e;
      model_gpio = model_rmw(model_gpio, o, m, d);
      e.idx = i;
      e.val = model_gpio;
      sb_q.push_back(e);
   endtask

   task automatic run_op(input int i, input logic [1:0] o, input logic [DATA_W-1:0] m,
                         input logic [DATA_W-1:0] d);
      set_req(i, o, m, d);
      expect_op(i, o, m, d);
      tick();
      check_val("op_we_n1", {63'd0, gpio_we}, 64'd1);
      check_val("op_wdata", {32'd0, gpio_wdata}, {32'd0, model_gpio});
      check_val("op_ack_n1", {60'd0, ack}, 64'd0);
      tick();
      check_val("op_ack_n2", {60'd0, ack}, 64'(1) << i);
      req[i] = 1'b0;
      tick();
      check_val("op_idle", {63'd0, busy}, 64'd0);
   endtask

   task automatic wait_ack(output int c);
      bit got;
      got = 1'b0;
      c = -1;
      for (int k = 0; k < 12 && !got; k++) begin
         tick();
         if (ack != '0) begin
            got = 1'b1;
            c = cyc;
         end
      end
      check_val("ack_timeout", {63'd0, got}, 64'd1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

   initial begin
      int c, c_prev;
      reset = 1'b1;
      req = '0; op = '0; mask = '0; data = '0;
      load_en = 1'b0; load_val = '0; model_gpio = '0;
`ifdef GPIO_ARB_LOCK_EN
      lock = '0;
`endif
      repeat (3) tick();
      check_val("rst_ack", {60'd0, ack}, 64'd0);
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_we", {63'd0, gpio_we}, 64'd0);
      check_val("rst_wdata", {32'd0, gpio_wdata}, 64'd0);
      check_val("rst_rsp", {32'd0, rsp_data}, 64'd0);
      reset = 1'b0;
      tick();

      // single requester WRITE
      preload(32'h0000_0000);
      run_op(1, 2'b00, 32'h0000_00FF, 32'h1234_5678);
      check_val("t1_gpio", {32'd0, gpio_rdata}, 64'h0000_0078);

      // SET / CLEAR / TOGGLE chain, data ignored
      preload(32'h0000_00F0);
      run_op(1, 2'b01, 32'h0000_000F, 32'hDEAD_BEEF);
      check_val("t2_set", {32'd0, gpio_rdata}, 64'h0000_00FF);
      run_op(1, 2'b10, 32'h0000_003C, 32'hDEAD_BEEF);
      check_val("t2_clear", {32'd0, gpio_rdata}, 64'h0000_00C3);
      run_op(1, 2'b11, 32'hFFFF_0000, 32'hDEAD_BEEF);
      check_val("t2_toggle", {32'd0, gpio_rdata}, 64'hFFFF_00C3);

      // mask=0 still writes and acks
      run_op(0, 2'b00, 32'h0000_0000, 32'hFFFF_FFFF);
      check_val("mask0_gpio", {32'd0, gpio_rdata}, 64'hFFFF_00C3);

      // requester withdraws during EXEC
      set_req(2, 2'b00, 32'hFFFF_0000, 32'hA5A5_1234);
      expect_op(2, 2'b00, 32'hFFFF_0000, 32'hA5A5_1234);
      tick();
      req[2] = 1'b0;
      check_val("t4_we", {63'd0, gpio_we}, 64'd1);
      tick();
      check_val("t4_ack", {60'd0, ack}, 64'h4);
      tick();
      check_val("t4_gpio", {32'd0, gpio_rdata}, 64'hA5A5_00C3);

      // reset during EXEC: write lands, ack dropped, rr_ptr back to 0
      set_req(3, 2'b11, 32'h0000_000F, 32'h0);
      tick();
      check_val("t5_we_exec", {63'd0, gpio_we}, 64'd1);
      reset = 1'b1;
      model_gpio = model_rmw(model_gpio, 2'b11, 32'h0000_000F, 32'h0);
      tick();
      check_val("t5_we", {63'd0, gpio_we}, 64'd0);
      check_val("t5_ack", {60'd0, ack}, 64'd0);
      check_val("t5_busy", {63'd0, busy}, 64'd0);
      reset = 1'b0;
      req = '0;
      tick();
      check_val("t5_ack_after", {60'd0, ack}, 64'd0);
      check_val("t5_gpio", {32'd0, gpio_rdata}, 64'hA5A5_00CC);
      set_req(1, 2'b01, 32'h0000_0100, 32'h0);
      set_req(3, 2'b10, 32'h0000_0001, 32'h0);
      expect_op(1, 2'b01, 32'h0000_0100, 32'h0);
      expect_op(3, 2'b10, 32'h0000_0001, 32'h0);
      wait_ack(c);
      req[1] = 1'b0;
      wait_ack(c);
      req[3] = 1'b0;
      tick();

      // fairness with all four requesting, rr_ptr at 0
      preload(32'h0000_0000);
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'b11, 32'h0000_000F << (8*i), 32'h0);
      expect_op(0, 2'b11, 32'h0000_000F, 32'h0);
      expect_op(1, 2'b11, 32'h0000_0F00, 32'h0);
      expect_op(2, 2'b11, 32'h000F_0000, 32'h0);
      expect_op(3, 2'b11, 32'h0F00_0000, 32'h0);
      expect_op(0, 2'b11, 32'h0000_000F, 32'h0);
      c_prev = -1;
      for (int k = 0; k < 5; k++) begin
         wait_ack(c);
         if (k > 0) check_val("t3_spacing", 64'(c - c_prev), 64'd3);
         c_prev = c;
      end
      req = '0;
      tick();
      check_val("t3_gpio", {32'd0, gpio_rdata}, 64'h0F0F_0F00);

`ifdef GPIO_ARB_LOCK_EN
      // lock keeps requester 0 for three ops, then requester 3 is served
      preload(32'h0000_0000);
      set_req(0, 2'b11, 32'h0000_0001, 32'h0);
      lock[0] = 1'b1;
      expect_op(0, 2'b11, 32'h0000_0001, 32'h0);
      expect_op(0, 2'b11, 32'h0000_0001, 32'h0);
      expect_op(0, 2'b11, 32'h0000_0001, 32'h0);
      expect_op(3, 2'b00, 32'h0000_FF00, 32'h0000_5500);
      tick();
      set_req(3, 2'b00, 32'h0000_FF00, 32'h0000_5500);
      wait_ack(c);
      wait_ack(c);
      tick();
      lock[0] = 1'b0;
      wait_ack(c);
      req[0] = 1'b0;
      wait_ack(c);
      req[3] = 1'b0;
      tick();
      check_val("t6_gpio", {32'd0, gpio_rdata}, 64'h0000_5501);
`endif

      repeat (2) tick();
      check_val("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
